// File: rtl/sha256_spi_master.sv
// SPI mode-3 master issuing 16-bit {wr, addr[6:0], data[7:0]} frames to the SHA-256 slave,
// plus a 2-flop synchroniser for the slave's done interrupt.
module sha256_spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SS_SETUP = 2,
    parameter int unsigned SS_GAP   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_wr,
    input  logic [6:0]  i_addr,
    input  logic [7:0]  i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rx_frame,
    output logic [7:0]  o_rdata,
    output logic        o_sck,
    output logic        o_ss_n,
    output logic        o_mosi,
    input  logic        i_miso,
    input  logic        i_irq_done,
    output logic        o_irq
);

    localparam int unsigned HalfW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SetupW = (SS_SETUP > 1) ? $clog2(SS_SETUP) : 1;
    localparam int unsigned GapW   = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;

    localparam logic [HalfW-1:0]  HalfLast  = HalfW'(CLK_DIV - 1);
    localparam logic [SetupW-1:0] SetupLast = SetupW'(SS_SETUP - 1);
    localparam logic [GapW-1:0]   GapLast   = GapW'(SS_GAP - 1);
    localparam logic              GapMulti  = (SS_GAP > 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e            state_q, state_d;
    logic [15:0]       tx_q, tx_d;
    logic [15:0]       rx_q, rx_d;
    logic [15:0]       rx_frame_q, rx_frame_d;
    logic              sck_q, sck_d;
    logic              ss_n_q, ss_n_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [HalfW-1:0]  half_cnt_q, half_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [SetupW-1:0] setup_cnt_q, setup_cnt_d;
    logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              irq_meta_q, irq_q;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rx_frame_d  = rx_frame_q;
        sck_d       = sck_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        half_cnt_d  = half_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        setup_cnt_d = setup_cnt_q;
        gap_cnt_d   = gap_cnt_q;

        // busy drops for the last gap cycle so a queued start keeps ss_n high exactly SS_GAP
        if (i_start && !busy_q) begin
            tx_d        = {i_wr, i_addr, i_wdata};
            state_d     = StSetup;
            ss_n_d      = 1'b0;
            sck_d       = 1'b1;
            busy_d      = 1'b1;
            setup_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSetup: begin
                    if (setup_cnt_q == SetupLast) begin
                        state_d    = StShift;
                        sck_d      = 1'b0;
                        mosi_d     = tx_q[15];
                        tx_d       = {tx_q[14:0], 1'b0};
                        half_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        setup_cnt_d = setup_cnt_q + SetupW'(1);
                    end
                end
                StShift: begin
                    if (half_cnt_q != HalfLast) begin
                        half_cnt_d = half_cnt_q + HalfW'(1);
                    end else begin
                        half_cnt_d = '0;
                        if (!sck_q) begin
                            sck_d     = 1'b1;
                            rx_d      = {rx_q[14:0], i_miso};
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end else if (bit_cnt_q == 5'd16) begin
                            state_d = StHold;
                        end else begin
                            sck_d  = 1'b0;
                            mosi_d = tx_q[15];
                            tx_d   = {tx_q[14:0], 1'b0};
                        end
                    end
                end
                StHold: begin
                    if (half_cnt_q != HalfLast) begin
                        half_cnt_d = half_cnt_q + HalfW'(1);
                    end else begin
                        state_d    = StGap;
                        ss_n_d     = 1'b1;
                        done_d     = 1'b1;
                        rx_frame_d = rx_q;
                        gap_cnt_d  = '0;
                        busy_d     = GapMulti;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_d = StIdle;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                        if (gap_cnt_q + GapW'(1) == GapLast) begin
                            busy_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            tx_q        <= '0;
            rx_q        <= '0;
            rx_frame_q  <= '0;
            sck_q       <= 1'b1;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            half_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            setup_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rx_frame_q  <= rx_frame_d;
            sck_q       <= sck_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            half_cnt_q  <= half_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            setup_cnt_q <= setup_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            irq_meta_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_meta_q <= i_irq_done;
            irq_q      <= irq_meta_q;
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rx_frame = rx_frame_q;
    assign o_rdata    = rx_frame_q[7:0];
    assign o_sck      = sck_q;
    assign o_ss_n     = ss_n_q;
    assign o_mosi     = mosi_q;
    assign o_irq      = irq_q;

endmodule

// File: tb/tb_sha256_spi_master.sv
// Bench for sha256_spi_master: waveform-level reference model checked every cycle, directed
// frames with literal expectations, randomized frames, and a CLK_DIV=6 timing check.
module tb_sha256_spi_master;

    localparam int CD      = 4;
    localparam int SU      = 2;
    localparam int GP      = 4;
    localparam int SHIFT_E = SU + 32 * CD;
    localparam int DONE_K  = SU + 33 * CD;
    localparam int BUSY_K  = DONE_K + GP - 1;
    localparam int CD6     = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, wr = 1'b0, miso = 1'b0, irq_in = 1'b0;
    logic [6:0]  addr  = '0;
    logic [7:0]  wdata = '0;
    logic        o_busy, o_done, o_sck, o_ss_n, o_mosi, o_irq;
    logic [15:0] o_rx_frame;
    logic [7:0]  o_rdata;

    logic        start6 = 1'b0, miso6 = 1'b0, irq6 = 1'b0;
    logic        busy6, done6, sck6, ss_n6, mosi6, irq6_o;
    logic [15:0] rx6;
    logic [7:0]  rdata6;

    sha256_spi_master #(.CLK_DIV(CD), .SS_SETUP(SU), .SS_GAP(GP)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_wr(wr), .i_addr(addr),
        .i_wdata(wdata), .o_busy(o_busy), .o_done(o_done), .o_rx_frame(o_rx_frame),
        .o_rdata(o_rdata), .o_sck(o_sck), .o_ss_n(o_ss_n), .o_mosi(o_mosi), .i_miso(miso),
        .i_irq_done(irq_in), .o_irq(o_irq)
    );

    sha256_spi_master #(.CLK_DIV(CD6), .SS_SETUP(SU), .SS_GAP(GP)) dut6 (
        .i_clk(clk), .i_rst(rst), .i_start(start6), .i_wr(1'b1), .i_addr(7'h2A),
        .i_wdata(8'h99), .o_busy(busy6), .o_done(done6), .o_rx_frame(rx6),
        .o_rdata(rdata6), .o_sck(sck6), .o_ss_n(ss_n6), .o_mosi(mosi6), .i_miso(miso6),
        .i_irq_done(irq6), .o_irq(irq6_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame accepted at posedge number fs defines the whole waveform as a
    // function of the cycle offset k = cyc - fs.
    int          cyc = 0;
    int          fs  = -1;
    logic [15:0] cur_tx = '0, pend_rx = '0, rx_done_val = '0, slave_pat = '0;
    logic        last_mosi = 1'b0, irq_d1 = 1'b0, irq_d2 = 1'b0, pb;

    function automatic logic exp_busy();
        return (fs >= 0) && ((cyc - fs) < BUSY_K);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            fs = -1; rx_done_val = '0; last_mosi = 1'b0; irq_d1 = 1'b0; irq_d2 = 1'b0;
        end else begin
            pb = exp_busy();
            cyc++;
            irq_d2 = irq_d1;
            irq_d1 = irq_in;
            if (start && !pb) begin
                if (fs >= 0) begin
                    rx_done_val = pend_rx;
                    last_mosi   = cur_tx[0];
                end
                fs      = cyc;
                cur_tx  = {wr, addr, wdata};
                pend_rx = slave_pat;
            end
        end
    end

    int          kc, bidx;
    logic [3:0]  bsel;
    logic        e_sck, e_ss_n, e_mosi, e_busy, e_done;
    logic [15:0] e_rx;
    logic        cmp_en = 1'b0;

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            kc     = (fs >= 0) ? cyc - fs : -1;
            e_busy = exp_busy();
            e_ss_n = !(kc >= 0 && kc < DONE_K);
            e_sck  = !(kc >= SU && kc < SHIFT_E && (((kc - SU) / CD) % 2 == 0));
            e_done = (kc == DONE_K);
            e_rx   = (kc >= DONE_K) ? pend_rx : rx_done_val;
            if (kc < SU) begin
                e_mosi = last_mosi;
            end else begin
                bidx = (kc - SU) / (2 * CD);
                if (bidx > 15) bidx = 15;
                bsel   = 4'(15 - bidx);
                e_mosi = cur_tx[bsel];
            end
            chk("cycle", 32'({o_sck, o_ss_n, o_mosi, o_busy, o_done, o_irq, o_rx_frame, o_rdata}),
                32'({e_sck, e_ss_n, e_mosi, e_busy, e_done, irq_d2, e_rx, e_rx[7:0]}));
        end
    end

    // Mode-3 slave: shifts the pattern out on SCK falling edges, MSB first.
    int          sidx = 0, falls = 0, ss_falls = 0, rises = 0;
    logic [15:0] spat = '0, cap = '0;
    always @(negedge o_ss_n) begin
        sidx = 0;
        spat = slave_pat;
        ss_falls++;
    end
    always @(negedge o_sck) begin
        if (!o_ss_n) begin
            falls++;
            if (sidx < 16) begin
                miso = spat[4'(15 - sidx)];
                sidx++;
            end
        end
    end
    always @(posedge o_sck) begin
        if (!o_ss_n) begin
            cap = {cap[14:0], o_mosi};
            rises++;
        end
    end

    int ss_low = 0, done_cnt = 0, hi_run = 0, last_hi_run = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (!o_ss_n) ss_low++;
            if (o_done) done_cnt++;
            if (o_ss_n) begin
                hi_run++;
            end else begin
                if (hi_run > 0) last_hi_run = hi_run;
                hi_run = 0;
            end
        end
    end

    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                        input logic [15:0] pat);
        slave_pat = pat;
        wr = w; addr = a; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
    endtask

    task automatic wait_done(input string name, output int lat);
        lat = 1;
        while (!o_done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!o_done) begin
            total++; bad++;
            $display("FAIL %s: o_done never seen, got 0 expected 1", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (o_busy) begin
            total++; bad++;
            $display("FAIL %s: o_busy stuck, got 1 expected 0", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int          lat, s0, s1, s2, s3, n, nf, nr, low6, bad_half;
    int          fall_t[16], rise_t[16];
    logic        prev6, seen_low;
    logic [15:0] f, p;
    logic        rand_irq_en = 1'b0;

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_outs", 32'({o_sck, o_ss_n, o_mosi, o_busy, o_done, o_irq, o_rx_frame, o_rdata}),
            32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00}));

        // IRQ synchroniser: 3-cycle pulse appears 2 cycles late, 3 cycles long
        irq_in = 1'b1;
        @(negedge clk); chk("irq_n1", 32'(o_irq), 32'd0);
        @(negedge clk); chk("irq_n2", 32'(o_irq), 32'd1);
        @(negedge clk); chk("irq_n3", 32'(o_irq), 32'd1);
        irq_in = 1'b0;
        @(negedge clk); chk("irq_n4", 32'(o_irq), 32'd1);
        @(negedge clk); chk("irq_n5", 32'(o_irq), 32'd0);

        // Write frame
        s0 = ss_low; s1 = done_cnt; s2 = falls; s3 = rises;
        send(1'b1, 7'h10, 8'hA5, 16'h0000);
        wait_done("wr", lat);
        chk("wr_latency", 32'(lat), 32'd135);
        chk("wr_mosi", 32'(cap), 32'h90A5);
        wait_idle("wr");
        chk("wr_ss_low", 32'(ss_low - s0), 32'd134);
        chk("wr_done_cnt", 32'(done_cnt - s1), 32'd1);
        chk("wr_falls", 32'(falls - s2), 32'd16);
        chk("wr_rises", 32'(rises - s3), 32'd16);

        // Read capture
        send(1'b0, 7'h05, 8'h00, 16'h8C3C);
        wait_done("rd", lat);
        chk("rd_frame", 32'(o_rx_frame), 32'h8C3C);
        chk("rd_data", 32'(o_rdata), 32'h3C);
        @(negedge clk);
        chk("rd_done_1cyc", 32'(o_done), 32'd0);
        wait_idle("rd");

        // Busy rejection, then back-to-back start
        s0 = ss_falls;
        send(1'b1, 7'h22, 8'h33, 16'h1234);
        repeat (9) @(negedge clk);
        start = 1'b1; wr = 1'b0; addr = 7'h7F;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy", lat);
        chk("busy_mosi", 32'(cap), 32'hA233);
        chk("busy_rx", 32'(o_rx_frame), 32'h1234);
        wait_idle("busy");
        chk("busy_one_frame", 32'(ss_falls - s0), 32'd1);
        send(1'b0, 7'h01, 8'h5A, 16'hBEEF);
        repeat (2) @(negedge clk);
        chk("b2b_gap", 32'(last_hi_run), 32'(GP));
        wait_done("b2b", lat);
        chk("b2b_rx", 32'(o_rx_frame), 32'hBEEF);
        chk("b2b_mosi", 32'(cap), 32'h015A);
        wait_idle("b2b");

        // Reset after 7th SCK rising edge
        s0 = done_cnt; s1 = rises; n = 0;
        send(1'b1, 7'h3C, 8'hC3, 16'h0F0F);
        while ((rises - s1) < 7 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rises", 32'(rises - s1), 32'd7);
        #2 rst = 1'b1;
        #1 chk("mid_rst_outs", 32'({o_sck, o_ss_n, o_busy, o_done}), 32'({1'b1, 1'b1, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_no_done", 32'(done_cnt - s0), 32'd0);
        send(1'b1, 7'h55, 8'h66, 16'h5555);
        wait_done("post_rst", lat);
        chk("post_rst_lat", 32'(lat), 32'd135);
        chk("post_rst_mosi", 32'(cap), 32'hD566);
        chk("post_rst_rx", 32'(o_rx_frame), 32'h5555);
        wait_idle("post_rst");

        // Randomized frames with stray starts and a toggling interrupt line
        rand_irq_en = 1'b1;
        fork
            while (rand_irq_en) begin
                @(negedge clk);
                if ($urandom_range(0, 3) == 0) irq_in = ~irq_in;
            end
        join_none
        for (int i = 0; i < 30; i++) begin
            wait_idle("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            f = 16'($urandom);
            p = 16'($urandom);
            send(f[15], f[14:8], f[7:0], p);
            for (int j = 0; j < 2; j++) begin
                repeat ($urandom_range(5, 40)) @(negedge clk);
                start = 1'b1; addr = 7'($urandom); wdata = 8'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            wait_done("rand", lat);
            chk("rand_mosi", 32'(cap), 32'(f));
            chk("rand_rx", 32'(o_rdata), 32'(p[7:0]));
        end
        rand_irq_en = 1'b0;
        wait_idle("rand_end");

        // CLK_DIV=6 instance: every SCK half-period inside the frame is 6 cycles
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        nf = 0; nr = 0; low6 = 0; n = 0; prev6 = sck6; seen_low = 1'b0;
        while (!(seen_low && ss_n6) && n < 600) begin
            if (!ss_n6) begin
                seen_low = 1'b1;
                low6++;
                if (prev6 && !sck6 && nf < 16) begin fall_t[nf] = n; nf++; end
                if (!prev6 && sck6 && nr < 16) begin rise_t[nr] = n; nr++; end
            end
            prev6 = sck6;
            @(negedge clk);
            n++;
        end
        chk("cd6_falls", 32'(nf), 32'd16);
        chk("cd6_rises", 32'(nr), 32'd16);
        chk("cd6_ss_low", 32'(low6), 32'(SU + 33 * CD6));
        bad_half = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < nf && i < nr && rise_t[i] - fall_t[i] != CD6) bad_half++;
            if (i < 15 && i + 1 < nf && i < nr && fall_t[i + 1] - rise_t[i] != CD6) bad_half++;
        end
        chk("cd6_half_periods", 32'(bad_half), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
